match_scanner: RTL

MATCH_SCANNER -- requirements
Module: match_scanner

---
 rtl/match_scanner.sv | 115 +++++++++++
 1 files changed

// File: rtl/match_scanner.sv
// Streams DEPTH words past an external equality comparator against a captured key
// and reports whether any matched, the first matching index and the match count.
module match_scanner #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_res,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] first_idx,
  output logic [IDX_W:0]   match_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] key_r;
  logic [IDX_W-1:0] idx_r;
  logic             accept_s;
  logic             start_s;

  assign cmp_a = key_r;
  assign cmp_b = din;

  // next-state decode and per-cycle start/accept qualifiers
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_s     = 1'b1;
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (din_valid) begin
          accept_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SCAN;
          end
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // state, key, index and result registers; status outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      key_r     <= '0;
      idx_r     <= '0;
      found     <= 1'b0;
      first_idx <= '0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s == SCAN);
      din_ready <= (state_nxt_s == SCAN);
      done      <= (state_nxt_s == DONE);
      if (start_s) begin
        key_r     <= key;
        idx_r     <= '0;
        found     <= 1'b0;
        first_idx <= '0;
        match_cnt <= '0;
      end else if (accept_s) begin
        // idx parks on the last word so a full 2^IDX_W scan never wraps
        if (idx_r != LAST_IDX) begin
          idx_r <= idx_r + IDX_ONE;
        end
        if (cmp_res) begin
          match_cnt <= match_cnt + CNT_ONE;
          if (!found) begin
            found     <= 1'b1;
            first_idx <= idx_r;
          end
        end
      end
    end
  end

endmodule
